ks_note_sequencer: RTL and testbench

Step sequencer that drives the Karplus-Strong string voice with a programmed note pattern. It holds a small table of per-step periods and, at a programmable tempo, presents `period_o` and a gated `pluck_o` to `ks_string`. Table and control inputs come from the SPI register map. The block runs in the `ks_string` clock domain (`clk_16`), so its outputs connect directly without synchronisers.

---
 rtl/ks_note_sequencer.sv | 142 ++++++++++++++
 tb/tb_ks_note_sequencer.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/ks_note_sequencer.sv
// Step sequencer feeding ks_string: per-step period table, programmable tempo and pluck gate.
// Optional KS_SEQ_SWING_EN adds swing_i, which lengthens odd-indexed steps.
module ks_note_sequencer #(
    parameter int NUM_STEPS   = 8,
    parameter int DATA_WIDTH  = 8,
    parameter int TEMPO_WIDTH = 12,
    localparam int STEP_W     = $clog2(NUM_STEPS)
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   run_i,
    input  logic                   loop_i,
    input  logic [STEP_W-1:0]      last_i,
    input  logic [TEMPO_WIDTH-1:0] tempo_i,
    input  logic [TEMPO_WIDTH-1:0] gate_len_i,
`ifdef KS_SEQ_SWING_EN
    input  logic [TEMPO_WIDTH-1:0] swing_i,
`endif
    input  logic                   wr_en_i,
    input  logic [STEP_W-1:0]      wr_addr_i,
    input  logic [DATA_WIDTH-1:0]  wr_data_i,
    output logic [DATA_WIDTH-1:0]  period_o,
    output logic                   pluck_o,
    output logic [STEP_W-1:0]      step_o,
    output logic                   busy_o,
    output logic                   done_o
);

    // state | meaning
    // IDLE  | stopped; outputs quiet, period_o holds last note
    // PLAY  | stepping through the table
    typedef enum logic {IDLE, PLAY} state_t;

    state_t                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   tbl_q [NUM_STEPS];
    logic [STEP_W-1:0]       step_q, start_idx;
    logic [TEMPO_WIDTH-1:0]  tick_q, len_q, gate_q, len_new, gate_new;
    logic [DATA_WIDTH-1:0]   period_q;
    logic                    note_q, done_q, armed_q;
    logic                    start, abort, done_d;

    assign gate_new = (gate_len_i == '0) ? TEMPO_WIDTH'(1) : gate_len_i;

`ifdef KS_SEQ_SWING_EN
    logic [TEMPO_WIDTH-1:0] base_len;
    logic [TEMPO_WIDTH:0]   swing_sum;
    assign base_len  = (tempo_i == '0) ? TEMPO_WIDTH'(1) : tempo_i;
    assign swing_sum = {1'b0, base_len} + {1'b0, swing_i};
    // len is the index of the final tick, so saturating it caps the step at 2^W clocks
    assign len_new   = !start_idx[0] ? base_len :
                       (swing_sum[TEMPO_WIDTH] ? '1 : swing_sum[TEMPO_WIDTH-1:0]);
`else
    assign len_new   = (tempo_i == '0) ? TEMPO_WIDTH'(1) : tempo_i;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        start     = 1'b0;
        start_idx = '0;
        abort     = 1'b0;
        done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (run_i && armed_q) begin
                    state_d = PLAY;
                    start   = 1'b1;
                end
            end
            PLAY: begin
                if (!run_i) begin
                    state_d = IDLE;
                    abort   = 1'b1;
                end else if (tick_q == len_q) begin
                    if (step_q != last_i) begin
                        start     = 1'b1;
                        start_idx = step_q + STEP_W'(1);
                    end else if (loop_i) begin
                        start = 1'b1;
                    end else begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NUM_STEPS; i++) tbl_q[i] <= '0;
        end else if (wr_en_i) begin
            tbl_q[wr_addr_i] <= wr_data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            step_q   <= '0;
            tick_q   <= '0;
            len_q    <= '0;
            gate_q   <= '0;
            note_q   <= 1'b0;
            period_q <= '0;
            done_q   <= 1'b0;
            armed_q  <= 1'b1;
        end else begin
            done_q <= done_d;
            // after a play-once finishes, run_i must go low before another start
            if (!run_i)      armed_q <= 1'b1;
            else if (done_d) armed_q <= 1'b0;

            if (start) begin
                step_q <= start_idx;
                tick_q <= '0;
                len_q  <= len_new;
                gate_q <= gate_new;
                note_q <= (tbl_q[start_idx] != '0);
                if (tbl_q[start_idx] != '0) period_q <= tbl_q[start_idx];
            end else if (state_q == PLAY) begin
                if (abort || done_d) begin
                    step_q <= '0;
                    note_q <= 1'b0;
                end else begin
                    tick_q <= tick_q + TEMPO_WIDTH'(1);
                end
            end
        end
    end

    assign busy_o   = (state_q == PLAY);
    assign pluck_o  = busy_o && note_q && (tick_q < gate_q) && (tick_q != len_q);
    assign step_o   = step_q;
    assign period_o = period_q;
    assign done_o   = done_q;

endmodule

// File: tb/tb_ks_note_sequencer.sv
// Self-checking bench for ks_note_sequencer: directed scenarios plus randomized patterns
// compared cycle by cycle against a trace built from the step/gate rules.
module tb_ks_note_sequencer;

    logic       clk_i = 1'b0;
    logic       rst_ni;
    logic       run_i, loop_i, wr_en_i;
    logic [2:0] last_i, wr_addr_i;
    logic [11:0] tempo_i, gate_len_i;
    logic [7:0] wr_data_i;
    logic [7:0] period_o;
    logic       pluck_o, busy_o, done_o;
    logic [2:0] step_o;
`ifdef KS_SEQ_SWING_EN
    logic [11:0] swing_i = '0;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       busy;
        logic [2:0] step;
        logic [7:0] period;
        logic       pluck;
        logic       done;
    } exp_t;

    exp_t q[$];
    logic [7:0] mdl_period;

    ks_note_sequencer dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .run_i(run_i), .loop_i(loop_i),
        .last_i(last_i), .tempo_i(tempo_i), .gate_len_i(gate_len_i),
`ifdef KS_SEQ_SWING_EN
        .swing_i(swing_i),
`endif
        .wr_en_i(wr_en_i), .wr_addr_i(wr_addr_i), .wr_data_i(wr_data_i),
        .period_o(period_o), .pluck_o(pluck_o), .step_o(step_o),
        .busy_o(busy_o), .done_o(done_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input int cyc, input logic [7:0] obs, input logic [7:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, expv);
        end
    endtask

    task automatic chk_rec(input exp_t e, input int cyc);
        chk("busy",   cyc, {7'd0, busy_o},  {7'd0, e.busy});
        chk("step",   cyc, {5'd0, step_o},  {5'd0, e.step});
        chk("period", cyc, period_o,        e.period);
        chk("pluck",  cyc, {7'd0, pluck_o}, {7'd0, e.pluck});
        chk("done",   cyc, {7'd0, done_o},  {7'd0, e.done});
    endtask

    function automatic exp_t mk(input logic b, input int k, input logic [7:0] p, input logic pl, input logic d);
        exp_t e;
        logic [2:0] s;
        s = 3'(k);
        e.busy = b; e.step = s; e.period = p; e.pluck = pl; e.done = d;
        return e;
    endfunction

    task automatic clk_step();
        @(posedge clk_i); #1;
    endtask

    // Expected trace: each step is len+1 clocks, a note plucks for min(gate,len) clocks,
    // rests keep the previous period. ta is the table for the first pass, tb afterwards.
    task automatic gen(input int ta[8], input int tb[8], input int last, input bit lp,
                       input int tempo, input int gatev, input int cap);
        int len, g, hi, pass, k, n, v;
        logic [7:0] p;
        len = (tempo == 0) ? 1 : tempo;
        g   = (gatev == 0) ? 1 : gatev;
        hi  = (g < len) ? g : len;
        pass = 0; k = 0; n = 0;
        p = mdl_period;
        q.delete();
        while (n < cap) begin
            v = (pass == 0) ? ta[k] : tb[k];
            if (v != 0) p = 8'(v);
            for (int c = 0; c <= len && n < cap; c++) begin
                q.push_back(mk(1'b1, k, p, (v != 0) && (c < hi), 1'b0));
                n++;
            end
            if (k == last) begin
                if (!lp) begin
                    if (n < cap) q.push_back(mk(1'b0, 0, p, 1'b0, 1'b1));
                    break;
                end
                k = 0;
                pass++;
            end else begin
                k++;
            end
        end
        mdl_period = p;
    endtask

    task automatic write_table(input int t[8]);
        for (int i = 0; i < 8; i++) begin
            wr_en_i = 1'b1; wr_addr_i = 3'(i); wr_data_i = 8'(t[i]);
            clk_step();
        end
        wr_en_i = 1'b0;
    endtask

    task automatic run_queue(input int wr_idx, input int wa, input int wd);
        run_i = 1'b1;
        for (int i = 0; i < q.size(); i++) begin
            clk_step();
            wr_en_i = 1'b0;
            chk_rec(q[i], i);
            if (i == wr_idx) begin
                wr_en_i = 1'b1; wr_addr_i = 3'(wa); wr_data_i = 8'(wd);
            end
        end
        wr_en_i = 1'b0;
    endtask

    task automatic idle_check(input int n);
        for (int i = 0; i < n; i++) begin
            clk_step();
            chk_rec(mk(1'b0, 0, mdl_period, 1'b0, 1'b0), 1000 + i);
        end
    endtask

    initial begin
        int ta[8];
        int tb[8];
        int len;
        rst_ni = 1'b0; run_i = 1'b0; loop_i = 1'b0; last_i = '0;
        tempo_i = '0; gate_len_i = '0; wr_en_i = 1'b0; wr_addr_i = '0; wr_data_i = '0;
        mdl_period = 8'h00;
        repeat (3) @(posedge clk_i);
        #1;
        chk_rec(mk(1'b0, 0, 8'h00, 1'b0, 1'b0), 0);
        rst_ni = 1'b1;
        clk_step();

        // reset mid-play
        ta = '{8'h20, 8'h20, 8'h20, 8'h20, 8'h20, 8'h20, 8'h20, 8'h20};
        write_table(ta);
        last_i = 3'd7; loop_i = 1'b1; tempo_i = 12'd5; gate_len_i = 12'd3;
        gen(ta, ta, 7, 1'b1, 5, 3, 13);
        run_queue(-1, 0, 0);
        #2 rst_ni = 1'b0;
        #1 chk_rec(mk(1'b0, 0, 8'h00, 1'b0, 1'b0), 2000);
        clk_step();
        chk_rec(mk(1'b0, 0, 8'h00, 1'b0, 1'b0), 2001);
        clk_step();
        chk_rec(mk(1'b0, 0, 8'h00, 1'b0, 1'b0), 2002);
        mdl_period = 8'h00;
        rst_ni = 1'b1;
        clk_step();
        chk("restart_busy", 2003, {7'd0, busy_o}, 8'd1);
        run_i = 1'b0;
        idle_check(1);

        // basic play
        ta = '{8'h20, 8'h18, 0, 8'h10, 0, 0, 0, 0};
        write_table(ta);
        last_i = 3'd3; loop_i = 1'b0; tempo_i = 12'd9; gate_len_i = 12'd3;
        gen(ta, ta, 3, 1'b0, 9, 3, 1000);
        chk("basic_len", 3000, 8'(q.size()), 8'd41);
        run_queue(-1, 0, 0);
        idle_check(3);
        run_i = 1'b0;
        idle_check(1);

        // long gate on back-to-back notes
        ta = '{8'h40, 8'h30, 0, 0, 0, 0, 0, 0};
        write_table(ta);
        last_i = 3'd1; tempo_i = 12'd4; gate_len_i = 12'd20;
        gen(ta, ta, 1, 1'b0, 4, 20, 1000);
        run_queue(-1, 0, 0);
        run_i = 1'b0;
        idle_check(1);

        // loop then abort at step 1 tick 2 of the second pass
        ta = '{8'h21, 8'h42, 0, 0, 0, 0, 0, 0};
        write_table(ta);
        last_i = 3'd1; loop_i = 1'b1; tempo_i = 12'd6; gate_len_i = 12'd2;
        gen(ta, ta, 1, 1'b1, 6, 2, 3 * 7 + 3);
        run_queue(-1, 0, 0);
        run_i = 1'b0;
        idle_check(2);

        // live write to the step currently playing
        ta = '{8'h11, 8'h22, 8'h44, 8'h55, 0, 0, 0, 0};
        tb = ta; tb[2] = 8'h33;
        write_table(ta);
        last_i = 3'd3; loop_i = 1'b1; tempo_i = 12'd3; gate_len_i = 12'd2;
        gen(ta, tb, 3, 1'b1, 3, 2, 32);
        run_queue(2 * 4 + 1, 2, 8'h33);
        run_i = 1'b0;
        idle_check(1);

        // randomized patterns, including tempo/gate of 0
        for (int it = 0; it < 8; it++) begin
            int lst, tmp, gt;
            bit lp;
            for (int i = 0; i < 8; i++)
                ta[i] = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 255));
            lst = int'($urandom_range(0, 7));
            tmp = int'($urandom_range(0, 6));
            gt  = int'($urandom_range(0, 8));
            lp  = (it == 7);
            write_table(ta);
            last_i = 3'(lst); loop_i = lp; tempo_i = 12'(tmp); gate_len_i = 12'(gt);
            len = (tmp == 0) ? 1 : tmp;
            gen(ta, ta, lst, lp, tmp, gt, lp ? (lst + 1) * (len + 1) * 2 + 1 : 1000);
            run_queue(-1, 0, 0);
            if (!lp) idle_check(1);
            run_i = 1'b0;
            idle_check(1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
